// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared slot-schedule constants and owner decode
// Purpose: constants and the slot-owner decode shared by the receive
//   deserializer and the transmit-side schedule model.
// Contents:
//   NCH, CHW        - channel count (also slot counter width), channel index width
//   IDLE_SLOT       - all-ones counter value; the slot no channel owns
//   slot_owner_t    - {idle, ch} decode result
//   slot_owner(cnt) - trailing-ones count of cnt plus idle flag
package readout_pkg;

  localparam int NCH = 8;
  localparam int CHW = 3;
  localparam logic [NCH-1:0] IDLE_SLOT = '1;

  typedef struct packed {
    logic           idle;
    logic [CHW-1:0] ch;
  } slot_owner_t;

  // Owner is the position of the lowest zero bit, which mirrors the divided
  // clock grant: channel k needs divider bits 0..k-1 high and bit k low.
  function automatic slot_owner_t slot_owner(input logic [NCH-1:0] cnt);
    slot_owner_t r;
    logic        found;
    r.idle = (cnt == IDLE_SLOT);
    r.ch   = '0;
    found  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && !cnt[k]) begin
        r.ch  = CHW'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// rtl/readout_fifo.sv - synchronous word FIFO with registered storage head
// Purpose: small FIFO between slot capture and the downstream consumer.
// Ports:
//   clk, rstb   - clock, asynchronous active-low reset (flushes contents)
//   push, din   - write request and word
//   pop         - read request; ignored when empty
//   dout        - head word, read from storage registers
//   full, empty - occupancy flags
module readout_fifo
  import readout_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_bus_deser.sv
// rtl/readout_bus_deser.sv - tristate readout bus slot deserializer
// Purpose: mirrors the channel divider chain with a slot counter, decodes
//   the owner of each slot, samples the bus and queues {channel, data}.
// Ports:
//   clk, rstb           - slot-rate clock, asynchronous active-low reset
//   en                  - counter and capture enable
//   sync                - frame alignment; reloads the counter, no capture
//   bus_d               - shared readout bus
//   ch_mask             - per-channel capture enable
//   out_valid/out_ready - output handshake
//   out_ch, out_data    - head word channel and data
//   ovf, clr_ovf        - sticky drop flag and its clear
module readout_bus_deser
  import readout_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NCH   = 8,
  parameter int CHW   = 3,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  input  logic           sync,
  input  logic [DW-1:0]  bus_d,
  input  logic [NCH-1:0] ch_mask,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  output logic           ovf,
  input  logic           clr_ovf
);

  logic [NCH-1:0]    cnt;
  slot_owner_t       own;
  logic [CHW-1:0]    own_ch;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [CHW+DW-1:0] din;
  logic [CHW+DW-1:0] head;

  assign own    = slot_owner(cnt);
  assign own_ch = CHW'(own.ch);

  // Decode uses the pre-increment count; a sync slot is never captured.
  assign push = en && !sync && !own.idle && ch_mask[own_ch];
  assign din  = {own_ch, bus_d};

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && full && !pop;

  assign out_ch   = head[CHW+DW-1:DW];
  assign out_data = head[DW-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (sync) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Set has priority so a drop coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  readout_fifo #(
    .W     (CHW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule
